fp_wrb_arbiter: RTL and testbench

Schedules floating-point writebacks from 4 execution requesters onto the 2 write ports of the FP physical register file. The requesters are falu1, falu2, lsu and fdivsqrt. Each requester has a 1-entry pending slot with a valid/ready handshake. Up to 2 slots are granted per cycle by rotating (round-robin) priority. The block sits between the FP execution units and the FP physical regfile, and also provides wakeup-visible write strobes.

---
 rtl/fp_wrb_pkg.sv | 19 +
 rtl/rr_pick2.sv | 44 ++++
 rtl/fp_wrb_arbiter.sv | 132 +++++++++++++
 tb/tb_fp_wrb_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wrb_pkg.sv
// Shared definitions for the FP writeback arbiter: requester count,
// requester index map and the writeback request record.
package fp_wrb_pkg;

  localparam int unsigned NUM_FP_WRB_REQ    = 4;
  localparam int unsigned FP_REG_SIZE_WIDTH = 6;
  localparam int unsigned FP_DATA_WIDTH     = 64;

  localparam int unsigned FALU1_IDX    = 0;
  localparam int unsigned FALU2_IDX    = 1;
  localparam int unsigned LSU_IDX      = 2;
  localparam int unsigned FDIVSQRT_IDX = 3;

  typedef struct packed {
    logic [FP_REG_SIZE_WIDTH-1:0] addr;
    logic [FP_DATA_WIDTH-1:0]     data;
  } fp_wrb_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Rotating-priority picker: scans the request mask starting at ptr_i and
// returns the first two set positions as one-hot grants with valid flags
// and binary indices. N must be a power of two.
module rr_pick2 #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt0_o,
  output logic [N-1:0]     gnt1_o,
  output logic             vld0_o,
  output logic             vld1_o,
  output logic [PTR_W-1:0] idx0_o,
  output logic [PTR_W-1:0] idx1_o
);

  // Walk the mask in rotated order, taking the first two requesters found.
  always_comb begin : p_scan
    logic [PTR_W-1:0] pos;
    gnt0_o = '0;
    gnt1_o = '0;
    vld0_o = 1'b0;
    vld1_o = 1'b0;
    idx0_o = '0;
    idx1_o = '0;
    pos    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = ptr_i + PTR_W'(i);
      if (req_i[pos]) begin
        if (!vld0_o) begin
          gnt0_o[pos] = 1'b1;
          vld0_o      = 1'b1;
          idx0_o      = pos;
        end else if (!vld1_o) begin
          gnt1_o[pos] = 1'b1;
          vld1_o      = 1'b1;
          idx1_o      = pos;
        end
      end
    end
  end

endmodule

// File: rtl/fp_wrb_arbiter.sv
// FP writeback arbiter: four 1-entry requester slots drained onto the two
// FP regfile write ports by round-robin priority, two grants per cycle.
module fp_wrb_arbiter
  import fp_wrb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = NUM_FP_WRB_REQ,
  parameter int unsigned REG_SIZE_WIDTH = FP_REG_SIZE_WIDTH,
  parameter int unsigned DATA_WIDTH     = FP_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*REG_SIZE_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic                            wr_first_valid_o,
  output logic [REG_SIZE_WIDTH-1:0]       wr_first_address_o,
  output logic [DATA_WIDTH-1:0]           wr_first_data_o,
  output logic                            wr_second_valid_o,
  output logic [REG_SIZE_WIDTH-1:0]       wr_second_address_o,
  output logic [DATA_WIDTH-1:0]           wr_second_data_o,
  output logic [NUM_REQ-1:0]              slot_busy_o
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        slot_full_q;
  logic [REG_SIZE_WIDTH-1:0] slot_addr_q [NUM_REQ];
  logic [DATA_WIDTH-1:0]     slot_data_q [NUM_REQ];
  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] gnt0, gnt1, grant, accept;
  logic               vld0, vld1;
  logic [PTR_W-1:0]   idx0, idx1;

  logic [REG_SIZE_WIDTH-1:0] first_addr, second_addr;
  logic [DATA_WIDTH-1:0]     first_data, second_data;

  rr_pick2 #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i  (slot_full_q),
    .ptr_i  (rr_ptr_q),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1),
    .vld0_o (vld0),
    .vld1_o (vld1),
    .idx0_o (idx0),
    .idx1_o (idx1)
  );

  assign grant       = gnt0 | gnt1;
  assign req_ready_o = ~slot_full_q | grant;

  assign slot_busy_o[FALU1_IDX]    = slot_full_q[FALU1_IDX];
  assign slot_busy_o[FALU2_IDX]    = slot_full_q[FALU2_IDX];
  assign slot_busy_o[LSU_IDX]      = slot_full_q[LSU_IDX];
  assign slot_busy_o[FDIVSQRT_IDX] = slot_full_q[FDIVSQRT_IDX];

  // Handshakes that load a slot; p0 writes are taken but never stored.
  always_comb begin
    accept = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      accept[k] = req_valid_i[k] & req_ready_o[k] &
                  (req_addr_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] != '0);
    end
  end

  // Pointer moves just past the last winner of this cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (vld1) begin
      rr_ptr_d = idx1 + PTR_W'(1);
    end else if (vld0) begin
      rr_ptr_d = idx0 + PTR_W'(1);
    end
  end

  // Port muxes fed only from slot registers; grants are zero when a port is
  // idle, so address/data fall back to zero.
  always_comb begin
    first_addr  = '0;
    first_data  = '0;
    second_addr = '0;
    second_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt0[k]) begin
        first_addr = slot_addr_q[k];
        first_data = slot_data_q[k];
      end
      if (gnt1[k]) begin
        second_addr = slot_addr_q[k];
        second_data = slot_data_q[k];
      end
    end
  end

  // Reset also blanks the ports in the cycle it is asserted, so slots that
  // are about to be dropped never reach the regfile.
  assign wr_first_valid_o    = vld0 & ~rst;
  assign wr_first_address_o  = rst ? '0 : first_addr;
  assign wr_first_data_o     = rst ? '0 : first_data;
  assign wr_second_valid_o   = vld1 & ~rst;
  assign wr_second_address_o = rst ? '0 : second_addr;
  assign wr_second_data_o    = rst ? '0 : second_data;

  // Slot fill/drain and round-robin pointer; a reload wins over a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (accept[k]) begin
          slot_full_q[k] <= 1'b1;
          slot_addr_q[k] <= req_addr_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
          slot_data_q[k] <= req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end else if (grant[k]) begin
          slot_full_q[k] <= 1'b0;
        end
      end
    end
  end

  // Rename guarantees unique destinations; both ports never target one prd.
  a_uniq_dest: assert property (@(posedge clk) disable iff (rst)
    (wr_first_valid_o && wr_second_valid_o) |->
      (wr_first_address_o != wr_second_address_o));

endmodule

// File: tb/tb_fp_wrb_arbiter.sv
// Bench for fp_wrb_arbiter: directed scenarios with a write scoreboard.
module tb_fp_wrb_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic              w0_valid, w1_valid;
  logic [AW-1:0]     w0_addr, w1_addr;
  logic [DW-1:0]     w0_data, w1_data;
  logic [NR-1:0]     slot_busy;

  fp_wrb_arbiter #(
    .NUM_REQ        (NR),
    .REG_SIZE_WIDTH (AW),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_addr_i          (req_addr),
    .req_data_i          (req_data),
    .wr_first_valid_o    (w0_valid),
    .wr_first_address_o  (w0_addr),
    .wr_first_data_o     (w0_data),
    .wr_second_valid_o   (w1_valid),
    .wr_second_address_o (w1_addr),
    .wr_second_data_o    (w1_data),
    .slot_busy_o         (slot_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          port;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  bit          mon_on = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic p);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.port = p;
    sb.push_back(e);
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic set_req(input int unsigned k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k]         = 1'b1;
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every port write must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (w0_valid) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_w0", {58'd0, w0_addr}, 64'hFFFF);
        end else begin
          e = sb.pop_front();
          check_eq("sb_w0_port", 64'd0, {63'd0, e.port});
          check_eq("sb_w0_addr", {58'd0, w0_addr}, {58'd0, e.addr});
          check_eq("sb_w0_data", w0_data, e.data);
        end
      end else begin
        check_eq("w0_idle_addr", {58'd0, w0_addr}, 64'd0);
      end
      if (w1_valid) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_w1", {58'd0, w1_addr}, 64'hFFFF);
        end else begin
          e = sb.pop_front();
          check_eq("sb_w1_port", 64'd1, {63'd0, e.port});
          check_eq("sb_w1_addr", {58'd0, w1_addr}, {58'd0, e.addr});
          check_eq("sb_w1_data", w1_data, e.data);
        end
      end else begin
        check_eq("w1_idle_data", w1_data, 64'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clear_req();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_on = 1'b1;
    #1;

    // Reset / idle state
    check_eq("rst_ready", {60'd0, req_ready}, 64'hF);
    check_eq("rst_w0v", {63'd0, w0_valid}, 64'd0);
    check_eq("rst_w1v", {63'd0, w1_valid}, 64'd0);
    check_eq("rst_busy", {60'd0, slot_busy}, 64'd0);
    check_eq("rst_ptr", {62'd0, dut.rr_ptr_q}, 64'd0);
    tick();

    // Single lsu write
    set_req(2, 6'd5, 64'hDEAD_BEEF);
    expect_wr(6'd5, 64'hDEAD_BEEF, 1'b0);
    #1 check_eq("single_ready", {63'd0, req_ready[2]}, 64'd1);
    tick();
    clear_req();
    #1;
    check_eq("single_w0v", {63'd0, w0_valid}, 64'd1);
    check_eq("single_w0a", {58'd0, w0_addr}, 64'd5);
    check_eq("single_w0d", w0_data, 64'hDEAD_BEEF);
    check_eq("single_w1v", {63'd0, w1_valid}, 64'd0);
    check_eq("single_busy", {60'd0, slot_busy}, 64'h4);
    tick();
    check_eq("single_ptr", {62'd0, dut.rr_ptr_q}, 64'd3);
    check_eq("single_drained", {63'd0, w0_valid}, 64'd0);

    // Full contention from rr_ptr = 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check_eq("cont_ptr0", {62'd0, dut.rr_ptr_q}, 64'd0);
    for (int unsigned k = 0; k < NR; k++) begin
      set_req(k, AW'(k + 1), 64'h1000 + 64'(k));
      expect_wr(AW'(k + 1), 64'h1000 + 64'(k), k[0]);
    end
    tick();
    clear_req();
    #1;
    check_eq("cont1_w0a", {58'd0, w0_addr}, 64'd1);
    check_eq("cont1_w1v", {63'd0, w1_valid}, 64'd1);
    check_eq("cont1_w1a", {58'd0, w1_addr}, 64'd2);
    check_eq("cont1_ready", {60'd0, req_ready}, 64'h3);
    tick();
    check_eq("cont2_w0a", {58'd0, w0_addr}, 64'd3);
    check_eq("cont2_w1a", {58'd0, w1_addr}, 64'd4);
    check_eq("cont2_ptr", {62'd0, dut.rr_ptr_q}, 64'd2);
    tick();
    check_eq("cont_end_ptr", {62'd0, dut.rr_ptr_q}, 64'd0);
    check_eq("cont_end_busy", {60'd0, slot_busy}, 64'd0);

    // Sustained falu1 streaming
    for (int unsigned i = 0; i < 8; i++) begin
      set_req(0, AW'(10 + i), 64'hA000 + 64'(i));
      expect_wr(AW'(10 + i), 64'hA000 + 64'(i), 1'b0);
      #1 check_eq("stream_ready", {63'd0, req_ready[0]}, 64'd1);
      if (i > 0) begin
        check_eq("stream_w0v", {63'd0, w0_valid}, 64'd1);
        check_eq("stream_w0a", {58'd0, w0_addr}, 64'(10 + i - 1));
      end
      tick();
    end
    clear_req();
    #1;
    check_eq("stream_last_a", {58'd0, w0_addr}, 64'd17);
    tick();
    check_eq("stream_done", {63'd0, w0_valid}, 64'd0);

    // Zero-address drop on fdivsqrt
    set_req(3, 6'd0, 64'hFFFF);
    #1 check_eq("zero_ready", {63'd0, req_ready[3]}, 64'd1);
    tick();
    clear_req();
    #1;
    check_eq("zero_busy", {63'd0, slot_busy[3]}, 64'd0);
    check_eq("zero_w0v", {63'd0, w0_valid}, 64'd0);
    check_eq("zero_ready_all", {60'd0, req_ready}, 64'hF);
    repeat (2) tick();

    // Reset with three slots pending
    set_req(0, 6'd20, 64'h20);
    set_req(1, 6'd21, 64'h21);
    set_req(2, 6'd22, 64'h22);
    tick();
    clear_req();
    rst = 1'b1;
    #1;
    check_eq("mid_busy", {60'd0, slot_busy}, 64'h7);
    check_eq("mid_rst_w0v", {63'd0, w0_valid}, 64'd0);
    check_eq("mid_rst_w1v", {63'd0, w1_valid}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("post_w0v", {63'd0, w0_valid}, 64'd0);
    check_eq("post_w1v", {63'd0, w1_valid}, 64'd0);
    check_eq("post_busy", {60'd0, slot_busy}, 64'd0);
    check_eq("post_ready", {60'd0, req_ready}, 64'hF);
    tick();
    check_eq("post2_w0v", {63'd0, w0_valid}, 64'd0);

    tick();
    mon_on = 1'b0;
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
